// File: rtl/trap_collect_if.sv
// Retire-side handshake between writeback and trap_collect.
// Signals:
//   in_valid/in_ready   retire handshake (ready driven by trap_collect)
//   in_pc, in_tval      PC and trap value of the retiring instruction
//   in_if_fault, in_illegal, in_ebreak, in_ld_fault, in_st_fault  exception flags
// Modports: master = writeback side, slave = trap_collect side.
interface trap_collect_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_tval;
  logic            in_if_fault;
  logic            in_illegal;
  logic            in_ebreak;
  logic            in_ld_fault;
  logic            in_st_fault;

  modport master (
    output in_valid, in_pc, in_tval,
    output in_if_fault, in_illegal, in_ebreak, in_ld_fault, in_st_fault,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_pc, in_tval,
    input  in_if_fault, in_illegal, in_ebreak, in_ld_fault, in_st_fault,
    output in_ready
  );
endinterface

// File: rtl/trap_collect.sv
// trap_collect: watches retiring instructions at writeback, captures the first
// faulting retire (cause/PC/tval), issues a one-cycle flush plus exactly one
// report pulse, then parks the core in HALT. Counts clean retires.
// Ports:
//   clock, reset_n      clock, asynchronous active-low reset
//   bus (slave)         retire handshake + exception flags (in_ready is the
//                       only combinational output)
//   ebreak, access_fault, invalid_inst  one-cycle report pulses
//   flush               one-cycle pipeline flush
//   trap_valid, trap_cause, trap_pc, trap_tval  captured trap (sticky)
//   halted              core halted
//   retire_cnt          clean retires since reset (wraps at 2^64)
// Optional feature: define TRAP_WDOG_EN to enable the no-retire watchdog
// (cause 15 after WDOG_CYCLES RUN cycles without an accept).
module trap_collect #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned WDOG_CYCLES = 1024
) (
  input  logic            clock,
  input  logic            reset_n,
  trap_collect_if.slave   bus,
  output logic            ebreak,
  output logic            access_fault,
  output logic            invalid_inst,
  output logic            flush,
  output logic            trap_valid,
  output logic [3:0]      trap_cause,
  output logic [XLEN-1:0] trap_pc,
  output logic [XLEN-1:0] trap_tval,
  output logic            halted,
  output logic [63:0]     retire_cnt
);

  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_REPORT = 2'd1,
    ST_HALT   = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_ebreak;
  logic            r_access_fault;
  logic            r_invalid_inst;
  logic            r_flush;
  logic            r_trap_valid;
  logic [3:0]      r_trap_cause;
  logic [XLEN-1:0] r_trap_pc;
  logic [XLEN-1:0] r_trap_tval;
  logic            r_halted;
  logic [63:0]     r_retire_cnt;

  logic            w_ready;
  logic            w_accept;
  logic            w_fault;
  logic            w_take;
  logic [3:0]      w_cause;
  logic [XLEN-1:0] w_pc;
  logic [XLEN-1:0] w_tval;

`ifdef TRAP_WDOG_EN
  logic [WDOG_W-1:0] r_wdog;
  logic              w_wdog_hit;
`else
  logic              w_unused_wdog;
  assign w_unused_wdog = (WDOG_W == 0);
`endif

  assign w_ready      = (r_state == ST_RUN);
  assign bus.in_ready = w_ready;
  assign w_accept     = bus.in_valid && w_ready;
  assign w_fault      = bus.in_if_fault | bus.in_illegal | bus.in_ebreak |
                        bus.in_ld_fault | bus.in_st_fault;

  // Trap selection: flag priority, then the watchdog (never coincides with an accept).
  always_comb begin
    w_take  = w_accept && w_fault;
    w_cause = 4'd0;
    w_pc    = bus.in_pc;
    w_tval  = bus.in_tval;
    if (bus.in_if_fault) begin
      w_cause = 4'd1;
      w_tval  = bus.in_pc;
    end else if (bus.in_illegal) begin
      w_cause = 4'd2;
    end else if (bus.in_ebreak) begin
      w_cause = 4'd3;
      w_tval  = '0;
    end else if (bus.in_ld_fault) begin
      w_cause = 4'd5;
    end else if (bus.in_st_fault) begin
      w_cause = 4'd7;
    end
`ifdef TRAP_WDOG_EN
    w_wdog_hit = w_ready && !w_accept && (r_wdog == WDOG_W'(WDOG_CYCLES - 1));
    if (w_wdog_hit) begin
      w_take  = 1'b1;
      w_cause = 4'd15;
      w_pc    = '0;
      w_tval  = '0;
    end
`endif
  end

  // RUN/REPORT/HALT controller with registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_RUN;
      r_ebreak       <= 1'b0;
      r_access_fault <= 1'b0;
      r_invalid_inst <= 1'b0;
      r_flush        <= 1'b0;
      r_trap_valid   <= 1'b0;
      r_trap_cause   <= 4'd0;
      r_trap_pc      <= '0;
      r_trap_tval    <= '0;
      r_halted       <= 1'b0;
      r_retire_cnt   <= 64'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_take) begin
            r_state        <= ST_REPORT;
            r_flush        <= 1'b1;
            r_trap_valid   <= 1'b1;
            r_trap_cause   <= w_cause;
            r_trap_pc      <= w_pc;
            r_trap_tval    <= w_tval;
            r_ebreak       <= (w_cause == 4'd3);
            r_invalid_inst <= (w_cause == 4'd2) || (w_cause == 4'd15);
            r_access_fault <= (w_cause == 4'd1) || (w_cause == 4'd5) ||
                              (w_cause == 4'd7);
          end else if (w_accept) begin
            r_retire_cnt <= r_retire_cnt + 64'd1;
          end
        end
        ST_REPORT: begin
          r_state        <= ST_HALT;
          r_flush        <= 1'b0;
          r_ebreak       <= 1'b0;
          r_access_fault <= 1'b0;
          r_invalid_inst <= 1'b0;
          r_halted       <= 1'b1;
        end
        default: begin
          r_state <= ST_HALT;
        end
      endcase
    end
  end

`ifdef TRAP_WDOG_EN
  // Idle-retire watchdog: any accept clears it; it only advances in RUN.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wdog <= '0;
    end else if (w_accept) begin
      r_wdog <= '0;
    end else if (w_ready && !w_wdog_hit) begin
      r_wdog <= r_wdog + WDOG_W'(1);
    end
  end
`endif

  assign ebreak       = r_ebreak;
  assign access_fault = r_access_fault;
  assign invalid_inst = r_invalid_inst;
  assign flush        = r_flush;
  assign trap_valid   = r_trap_valid;
  assign trap_cause   = r_trap_cause;
  assign trap_pc      = r_trap_pc;
  assign trap_tval    = r_trap_tval;
  assign halted       = r_halted;
  assign retire_cnt   = r_retire_cnt;

endmodule
